// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - streams a byte image into the 16x8 ram while the CPU is halted
// Optional readback checksum verify is enabled by defining MEM_LOADER_VERIFY_EN.
module mem_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] cpu_mar,
  input  logic              cpu_ri,
  input  logic              cpu_ro,
  input  logic [DATA_W-1:0] cpu_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              ri,
  output logic              ro,
  output logic [DATA_W-1:0] data_i,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD
`ifdef MEM_LOADER_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;
  logic [DATA_W-1:0]   sum, sum_n;
  logic [DATA_W-1:0]   checksum_n;
  logic                done_n, error_n;
`ifdef MEM_LOADER_VERIFY_EN
  logic [DATA_W-1:0]   vsum, vsum_n;
`else
  logic                unused_rdata;
  assign unused_rdata = ^ram_rdata;
`endif

  assign busy     = (state != IDLE);
  assign cpu_halt = busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      sum      <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      checksum <= '0;
`ifdef MEM_LOADER_VERIFY_EN
      vsum     <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sum      <= sum_n;
      done     <= done_n;
      error    <= error_n;
      checksum <= checksum_n;
`ifdef MEM_LOADER_VERIFY_EN
      vsum     <= vsum_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    sum_n       = sum;
    done_n      = done;
    error_n     = error;
    checksum_n  = checksum;
`ifdef MEM_LOADER_VERIFY_EN
    vsum_n      = vsum;
`endif
    mem_address = cpu_mar;
    ri          = cpu_ri;
    ro          = cpu_ro;
    data_i      = cpu_data;
    in_ready    = 1'b0;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_n = LOAD;
          cnt_n   = '0;
          sum_n   = '0;
          done_n  = 1'b0;
          error_n = 1'b0;
        end
      end

      LOAD: begin
        mem_address = cnt;
        data_i      = in_data;
        ro          = 1'b0;
        ri          = 1'b0;
        // abort withdraws in_ready so the upstream byte is not consumed
        if (abort) begin
          state_n = IDLE;
          error_n = 1'b1;
          done_n  = 1'b0;
        end else begin
          in_ready = 1'b1;
          ri       = in_valid;
          if (in_valid) begin
            cnt_n = cnt + 1'b1;
            sum_n = sum + in_data;
            if (cnt == LAST) begin
              checksum_n = sum + in_data;
              cnt_n      = '0;
`ifdef MEM_LOADER_VERIFY_EN
              vsum_n     = '0;
              state_n    = VERIFY;
`else
              state_n    = IDLE;
              done_n     = 1'b1;
`endif
            end
          end
        end
      end

`ifdef MEM_LOADER_VERIFY_EN
      VERIFY: begin
        mem_address = cnt;
        data_i      = '0;
        ri          = 1'b0;
        ro          = 1'b1;
        if (abort) begin
          state_n = IDLE;
          error_n = 1'b1;
          done_n  = 1'b0;
        end else begin
          vsum_n = vsum + ram_rdata;
          cnt_n  = cnt + 1'b1;
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = IDLE;
            done_n  = 1'b1;
            error_n = ((vsum + ram_rdata) != checksum);
          end
        end
      end
`endif

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - directed self-checking bench for mem_loader with a 16x8 ram model
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] cpu_mar = 4'h0;
  logic       cpu_ri = 1'b0, cpu_ro = 1'b0;
  logic [7:0] cpu_data = 8'h00;
  logic [3:0] mem_address;
  logic       ri, ro;
  logic [7:0] data_i, ram_rdata;
  logic       cpu_halt, busy, done, error;
  logic [7:0] checksum;

  logic [7:0] mem [16];
  logic       clr = 1'b0;
  logic       corrupt = 1'b0;
  int         total = 0;
  int         bad = 0;

`ifdef MEM_LOADER_VERIFY_EN
  localparam int EXP_VCYC = 16;
  localparam int EXP_VERR = 1;
`else
  localparam int EXP_VCYC = 0;
  localparam int EXP_VERR = 0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr) begin
      for (int j = 0; j < 16; j++) mem[j] <= 8'hFF;
    end else if (ri) begin
      mem[mem_address] <= data_i;
    end
  end

  assign ram_rdata = mem[mem_address] ^
                     ((corrupt && busy && ro && mem_address == 4'd7) ? 8'h01 : 8'h00);

  mem_loader dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cpu_mar(cpu_mar), .cpu_ri(cpu_ri), .cpu_ro(cpu_ro), .cpu_data(cpu_data),
    .mem_address(mem_address), .ri(ri), .ro(ro), .data_i(data_i),
    .ram_rdata(ram_rdata), .cpu_halt(cpu_halt), .busy(busy),
    .done(done), .error(error), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram;
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  // feeds bytes 0..15, with in_valid high every gap-th cycle
  task automatic load_image(input int gap);
    int i = 0;
    int k = 0;
    while (i < 16 && k < 200) begin
      in_valid = ((k % gap) == 0);
      in_data  = 8'(i);
      #1;
      chk("busy_load", 32'(busy), 1);
      chk("ri_follows_valid", 32'(ri), 32'(in_valid));
      if (in_valid) chk("wr_addr", 32'(mem_address), i);
      step();
      if (in_valid) i++;
      k++;
    end
    in_valid = 1'b0;
    chk("load_budget", 32'(i), 16);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int n;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_checksum", 32'(checksum), 0);
    rst = 1'b0;
    step();

    // pass-through after reset
    cpu_mar = 4'd5; cpu_ro = 1'b1; cpu_ri = 1'b0;
    #1;
    chk("pt_addr", 32'(mem_address), 5);
    chk("pt_ro", 32'(ro), 1);
    chk("pt_ri", 32'(ri), 0);
    chk("pt_busy", 32'(busy), 0);
    chk("pt_halt", 32'(cpu_halt), 0);
    chk("pt_done", 32'(done), 0);
    chk("pt_error", 32'(error), 0);
    cpu_ro = 1'b0;

    // start together with abort is ignored
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_ignored", 32'(busy), 0);
    clear_ram();

    // full contiguous load
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_in_ready", 32'(in_ready), 1);
    load_image(1);
    wait_idle(n);
    chk("verify_cycles", 32'(n), EXP_VCYC);
    chk("full_done", 32'(done), 1);
    chk("full_error", 32'(error), 0);
    chk("full_checksum", 32'(checksum), 32'h78);
    for (int j = 0; j < 16; j++) chk("full_mem", 32'(mem[j]), j);
    cpu_mar = 4'd3; cpu_ro = 1'b1;
    #1;
    chk("cpu_read3", 32'(ram_rdata), 3);
    cpu_ro = 1'b0;

    // gapped stream with CPU strobes asserted that must be ignored
    clear_ram();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("gap_done_cleared", 32'(done), 0);
    cpu_mar = 4'hC; cpu_ri = 1'b1; cpu_data = 8'hEE;
    load_image(3);
    wait_idle(n);
    cpu_ri = 1'b0;
    chk("gap_done", 32'(done), 1);
    chk("gap_error", 32'(error), 0);
    chk("gap_checksum", 32'(checksum), 32'h78);
    chk("gap_mem12", 32'(mem[12]), 12);
    chk("gap_mem15", 32'(mem[15]), 15);

    // corrupted readback at address 7
    corrupt = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    load_image(1);
    wait_idle(n);
    corrupt = 1'b0;
    chk("mis_done", 32'(done), 1);
    chk("mis_error", 32'(error), EXP_VERR);
    chk("mis_checksum", 32'(checksum), 32'h78);

    // abort after 6 accepted bytes
    clear_ram();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_data = 8'(j);
      step();
    end
    in_data = 8'hAA; abort = 1'b1;
    #1;
    chk("abort_ri", 32'(ri), 0);
    chk("abort_in_ready", 32'(in_ready), 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_halt", 32'(cpu_halt), 0);
    chk("abort_error", 32'(error), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_mem6", 32'(mem[6]), 32'hFF);
    chk("abort_mem5", 32'(mem[5]), 5);

    // restart: error clears, writes begin at 0
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_error", 32'(error), 0);
    in_valid = 1'b1; in_data = 8'h55;
    #1;
    chk("restart_addr", 32'(mem_address), 0);
    chk("restart_ri", 32'(ri), 1);
    step();
    chk("restart_mem0", 32'(mem[0]), 32'h55);
    for (int j = 1; j < 9; j++) begin
      in_data = 8'(j);
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("cnt9_addr", 32'(mem_address), 9);

    // asynchronous reset mid-load
    cpu_mar = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_halt", 32'(cpu_halt), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_error", 32'(error), 0);
    chk("arst_checksum", 32'(checksum), 0);
    step();
    rst = 1'b0;
    cpu_mar = 4'hA;
    step();
    chk("arst_passthrough", 32'(mem_address), 32'hA);
    chk("arst_still_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
